// File: rtl/hc_encode_tx.sv
// hc_encode_tx: Hamming(7,4) encoder with bit-serial transmit, position 1 first.
// Optional HC_ERR_INJ_EN adds single-bit error injection on the serial stream.
module hc_encode_tx #(
    parameter int IDLE_GAP = 0,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:1]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_ser_bit,
    output logic             o_ser_valid,
    output logic             o_ser_sof,
    output logic             o_ser_eof,
    output logic [7:1]       o_enc_data,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic             o_busy
`ifdef HC_ERR_INJ_EN
    ,
    input  logic             i_inj_en,
    input  logic [2:0]       i_inj_pos,
    output logic [CNT_W-1:0] o_inj_cnt
`endif
);

    localparam logic [7:0] GAP_LD = 8'(IDLE_GAP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:1]       ser_q, ser_d;
    logic [7:1]       enc_q, enc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:1]       flip;
    logic [7:1]       cw;
    logic             accept;

    function automatic logic [7:1] encode(input logic [4:1] d);
        logic [7:1] c;
        c[3] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = d[4];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return c;
    endfunction

    assign cw = encode(i_data);

`ifdef HC_ERR_INJ_EN
    logic [CNT_W-1:0] inj_cnt_q;

    always_comb begin
        flip = '0;
        if (i_inj_en && i_inj_pos != 3'd0)
            flip = 7'b1 << (i_inj_pos - 3'd1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            inj_cnt_q <= '0;
        else if (accept && flip != '0)
            inj_cnt_q <= inj_cnt_q + 1'b1;
    end

    assign o_inj_cnt = inj_cnt_q;
`else
    assign flip = '0;
`endif

    // Back-to-back mode can take the next word during the last bit.
    assign o_ready = i_rst_n
                   && ((state_q == IDLE)
                    || (state_q == SHIFT && idx_q == 3'd7 && GAP_LD == 8'd0));
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        ser_d   = ser_q;
        enc_d   = enc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: ;
            SHIFT: begin
                ser_d = ser_q >> 1;
                if (idx_q == 3'd7) begin
                    // The IDLE accept cycle is the last idle cycle of the gap.
                    if (GAP_LD > 8'd1) begin
                        state_d = GAP;
                        gap_d   = GAP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd2)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = SHIFT;
            idx_d   = 3'd1;
            enc_d   = cw;
            ser_d   = cw ^ flip;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            ser_q   <= '0;
            enc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            ser_q   <= ser_d;
            enc_q   <= enc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ser_valid = (state_q == SHIFT);
    assign o_ser_bit   = o_ser_valid && ser_q[1];
    assign o_ser_sof   = o_ser_valid && (idx_q == 3'd1);
    assign o_ser_eof   = o_ser_valid && (idx_q == 3'd7);
    assign o_enc_data  = enc_q;
    assign o_word_cnt  = cnt_q;
    assign o_busy      = (state_q != IDLE);

endmodule
